// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the dual-issue hazard scoreboard: register width,
// FSM encodings and the per-stage tag bundle.
package hazard_scoreboard_pkg;

    localparam int NUM_REGISTERS_LOG2 = 5;

    typedef enum logic {
        SB_NORMAL = 1'b0,
        SB_SPLIT  = 1'b1
    } sb_state_e;

    typedef struct packed {
        logic [NUM_REGISTERS_LOG2-1:0] rd0;
        logic [NUM_REGISTERS_LOG2-1:0] rd1;
        logic                          reg_write0;
        logic                          reg_write1;
        logic                          mem_read0;
        logic                          mem_read1;
        logic                          first;
    } sb_tag_t;

    localparam int SB_TAG_W = $bits(sb_tag_t);

    // r0 is hardwired, so it can never be the source of a hazard
    function automatic logic reg_hit(
        input logic [NUM_REGISTERS_LOG2-1:0] rd,
        input logic [NUM_REGISTERS_LOG2-1:0] rs,
        input logic [NUM_REGISTERS_LOG2-1:0] rt
    );
        return (rd != '0) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/hazard_scoreboard_stage_reg.sv
// One pipeline stage worth of hazard tags; bubble kills the write
// and load flags while still letting the register numbers through.
module sb_stage_reg
    import hazard_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bubble,
    input  logic [SB_TAG_W-1:0] in_tag,
    output logic [SB_TAG_W-1:0] out_tag
);

    sb_tag_t tag_d;
    sb_tag_t tag_q;

    always_comb begin
        tag_d = sb_tag_t'(in_tag);
        if (bubble) begin
            tag_d.reg_write0 = 1'b0;
            tag_d.reg_write1 = 1'b0;
            tag_d.mem_read0  = 1'b0;
            tag_d.mem_read1  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign out_tag = tag_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Dual-issue decode hazard scoreboard: load-use and intra-bundle RAW
// detection, bundle splitting FSM and id_ex/ex_mem/mem_wb tag pipe.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter logic ZERO_REG_WRITES = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid0,
    input  logic                          id_valid1,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rs0,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rt0,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rs1,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rt1,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rd0,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rd1,
    input  logic                          id_reg_write0,
    input  logic                          id_reg_write1,
    input  logic                          id_mem_read0,
    input  logic                          id_mem_read1,
    input  logic                          id_first,
    input  logic                          flush,
    output logic                          stall,
    output logic                          issue0,
    output logic                          issue1,
    output logic [NUM_REGISTERS_LOG2-1:0] id_ex_rd0,
    output logic [NUM_REGISTERS_LOG2-1:0] id_ex_rd1,
    output logic                          id_ex_reg_write0,
    output logic                          id_ex_reg_write1,
    output logic                          id_ex_first,
    output logic [NUM_REGISTERS_LOG2-1:0] ex_mem_rd0,
    output logic [NUM_REGISTERS_LOG2-1:0] ex_mem_rd1,
    output logic                          ex_mem_reg_write0,
    output logic                          ex_mem_reg_write1,
    output logic                          ex_mem_first,
    output logic [NUM_REGISTERS_LOG2-1:0] mem_wb_rd0,
    output logic [NUM_REGISTERS_LOG2-1:0] mem_wb_rd1,
    output logic                          mem_wb_reg_write0,
    output logic                          mem_wb_reg_write1,
    output logic                          mem_wb_first
);

    sb_state_e state_d, state_q;
    sb_tag_t   id_ex_d, id_ex_tag, ex_mem_tag, mem_wb_tag;

    logic [NUM_REGISTERS_LOG2-1:0] old_rd, yng_rs, yng_rt;
    logic old_wr, ld0, ld1, hit0, hit1, pend0, pend1;
    logic load_use, intra;

    // id_first=1 means slot0 is the older instruction of the bundle
    always_comb begin
        old_rd = id_first ? id_rd0 : id_rd1;
        old_wr = id_first ? id_reg_write0 : id_reg_write1;
        yng_rs = id_first ? id_rs1 : id_rs0;
        yng_rt = id_first ? id_rt1 : id_rt0;
        ld0    = id_ex_tag.mem_read0 & id_ex_tag.reg_write0;
        ld1    = id_ex_tag.mem_read1 & id_ex_tag.reg_write1;
        hit0   = (ld0 & reg_hit(id_ex_tag.rd0, id_rs0, id_rt0))
               | (ld1 & reg_hit(id_ex_tag.rd1, id_rs0, id_rt0));
        hit1   = (ld0 & reg_hit(id_ex_tag.rd0, id_rs1, id_rt1))
               | (ld1 & reg_hit(id_ex_tag.rd1, id_rs1, id_rt1));
        pend0  = id_valid0 & ((state_q == SB_NORMAL) | ~id_first);
        pend1  = id_valid1 & ((state_q == SB_NORMAL) | id_first);
        load_use = (pend0 & hit0) | (pend1 & hit1);
        intra  = id_valid0 & id_valid1 & old_wr
               & reg_hit(old_rd, yng_rs, yng_rt);
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        issue0  = 1'b0;
        issue1  = 1'b0;
        if (!rst_n) begin
            state_d = SB_NORMAL;
        end else if (flush) begin
            state_d = SB_NORMAL;
        end else if (load_use) begin
            stall = 1'b1;
        end else if (state_q == SB_SPLIT) begin
            issue0  = pend0;
            issue1  = pend1;
            state_d = SB_NORMAL;
        end else if (intra) begin
            issue0  = id_first;
            issue1  = ~id_first;
            stall   = 1'b1;
            state_d = SB_SPLIT;
        end else begin
            issue0 = id_valid0;
            issue1 = id_valid1;
        end
    end

    always_comb begin
        id_ex_d            = '0;
        id_ex_d.rd0        = id_rd0;
        id_ex_d.rd1        = id_rd1;
        id_ex_d.first      = id_first;
        id_ex_d.reg_write0 = issue0 & id_reg_write0
                           & (ZERO_REG_WRITES | (id_rd0 != '0));
        id_ex_d.reg_write1 = issue1 & id_reg_write1
                           & (ZERO_REG_WRITES | (id_rd1 != '0));
        id_ex_d.mem_read0  = issue0 & id_mem_read0;
        id_ex_d.mem_read1  = issue1 & id_mem_read1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SB_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    sb_stage_reg u_id_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (flush),
        .in_tag  (id_ex_d),
        .out_tag (id_ex_tag)
    );

    sb_stage_reg u_ex_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (1'b0),
        .in_tag  (id_ex_tag),
        .out_tag (ex_mem_tag)
    );

    sb_stage_reg u_mem_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (1'b0),
        .in_tag  (ex_mem_tag),
        .out_tag (mem_wb_tag)
    );

    assign id_ex_rd0         = id_ex_tag.rd0;
    assign id_ex_rd1         = id_ex_tag.rd1;
    assign id_ex_reg_write0  = id_ex_tag.reg_write0;
    assign id_ex_reg_write1  = id_ex_tag.reg_write1;
    assign id_ex_first       = id_ex_tag.first;
    assign ex_mem_rd0        = ex_mem_tag.rd0;
    assign ex_mem_rd1        = ex_mem_tag.rd1;
    assign ex_mem_reg_write0 = ex_mem_tag.reg_write0;
    assign ex_mem_reg_write1 = ex_mem_tag.reg_write1;
    assign ex_mem_first      = ex_mem_tag.first;
    assign mem_wb_rd0        = mem_wb_tag.rd0;
    assign mem_wb_rd1        = mem_wb_tag.rd1;
    assign mem_wb_reg_write0 = mem_wb_tag.reg_write0;
    assign mem_wb_reg_write1 = mem_wb_tag.reg_write1;
    assign mem_wb_first      = mem_wb_tag.first;

    // load flags are dead once the instruction leaves memory
    logic unused_mem_wb;
    assign unused_mem_wb = ^{mem_wb_tag.mem_read0, mem_wb_tag.mem_read1};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: randomized and directed decode
// bundles against a rule-level reference model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int  R   = NUM_REGISTERS_LOG2;
    localparam logic ZRW = 1'b0;

    typedef struct packed {
        logic vl0, vl1;
        logic [R-1:0] rs0, rt0, rs1, rt1, rd0, rd1;
        logic wr0, wr1, ld0, ld1;
        logic first;
        logic fl;
    } stim_t;

    typedef struct packed {
        logic [R-1:0] rd0, rd1;
        logic rw0, rw1, mr0, mr1, first;
    } mtag_t;

    typedef struct packed {
        logic [2:0]     ctl;
        logic [2*R+2:0] ie, em, mw;
    } exp_t;

    logic clk, rst_n;
    stim_t cur;
    logic stall, issue0, issue1;
    logic [R-1:0] ie_rd0, ie_rd1, em_rd0, em_rd1, mw_rd0, mw_rd1;
    logic ie_rw0, ie_rw1, ie_f, em_rw0, em_rw1, em_f, mw_rw0, mw_rw1, mw_f;

    hazard_scoreboard #(.ZERO_REG_WRITES(ZRW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid0(cur.vl0), .id_valid1(cur.vl1),
        .id_rs0(cur.rs0), .id_rt0(cur.rt0),
        .id_rs1(cur.rs1), .id_rt1(cur.rt1),
        .id_rd0(cur.rd0), .id_rd1(cur.rd1),
        .id_reg_write0(cur.wr0), .id_reg_write1(cur.wr1),
        .id_mem_read0(cur.ld0), .id_mem_read1(cur.ld1),
        .id_first(cur.first), .flush(cur.fl),
        .stall(stall), .issue0(issue0), .issue1(issue1),
        .id_ex_rd0(ie_rd0), .id_ex_rd1(ie_rd1),
        .id_ex_reg_write0(ie_rw0), .id_ex_reg_write1(ie_rw1),
        .id_ex_first(ie_f),
        .ex_mem_rd0(em_rd0), .ex_mem_rd1(em_rd1),
        .ex_mem_reg_write0(em_rw0), .ex_mem_reg_write1(em_rw1),
        .ex_mem_first(em_f),
        .mem_wb_rd0(mw_rd0), .mem_wb_rd1(mw_rd1),
        .mem_wb_reg_write0(mw_rw0), .mem_wb_reg_write1(mw_rw1),
        .mem_wb_first(mw_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // reference model: pipe[0]=id_ex, pipe[1]=ex_mem, pipe[2]=mem_wb
    mtag_t m_pipe[3];
    mtag_t m_next;
    bit    m_split, m_split_next, m_last_stall;

    function automatic bit hits(logic [R-1:0] rd, logic [R-1:0] rs,
                                logic [R-1:0] rt);
        return (rd != 0) && (rd == rs || rd == rt);
    endfunction

    function automatic logic [2*R+2:0] vis(mtag_t t);
        return {t.rd0, t.rd1, t.rw0, t.rw1, t.first};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) m_pipe[i] = '0;
        m_next = '0;
        m_split = 0;
        m_split_next = 0;
    endtask

    task automatic model_advance();
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = m_next;
        m_split   = m_split_next;
    endtask

    task automatic compute(input stim_t s, output exp_t e);
        bit vl[2], wr[2], ld[2], iss[2], pend[2], prw[2], pmr[2];
        logic [R-1:0] rs[2], rt[2], rd[2], prd[2];
        bit lu, intra, stl;
        int y, o;
        vl = '{s.vl0, s.vl1};  wr = '{s.wr0, s.wr1};
        ld = '{s.ld0, s.ld1};  rs = '{s.rs0, s.rs1};
        rt = '{s.rt0, s.rt1};  rd = '{s.rd0, s.rd1};
        prd = '{m_pipe[0].rd0, m_pipe[0].rd1};
        prw = '{m_pipe[0].rw0, m_pipe[0].rw1};
        pmr = '{m_pipe[0].mr0, m_pipe[0].mr1};
        y = s.first ? 1 : 0;
        o = 1 - y;
        lu = 0;
        for (int j = 0; j < 2; j++) begin
            pend[j] = vl[j] && (!m_split || j == y);
            for (int k = 0; k < 2; k++)
                if (pend[j] && pmr[k] && prw[k] && hits(prd[k], rs[j], rt[j]))
                    lu = 1;
        end
        intra = vl[0] && vl[1] && wr[o] && hits(rd[o], rs[y], rt[y]);
        iss = '{0, 0};
        stl = 0;
        m_split_next = m_split;
        if (!rst_n) begin
            model_clear();
        end else if (s.fl) begin
            m_split_next = 0;
        end else if (lu) begin
            stl = 1;
        end else if (m_split) begin
            iss[y] = vl[y];
            m_split_next = 0;
        end else if (intra) begin
            iss[o] = 1;
            stl = 1;
            m_split_next = 1;
        end else begin
            iss = vl;
        end
        m_next.rd0   = rd[0];
        m_next.rd1   = rd[1];
        m_next.first = s.first;
        m_next.rw0   = iss[0] && wr[0] && (ZRW || rd[0] != 0);
        m_next.rw1   = iss[1] && wr[1] && (ZRW || rd[1] != 0);
        m_next.mr0   = iss[0] && ld[0];
        m_next.mr1   = iss[1] && ld[1];
        m_last_stall = stl;
        e.ctl = {stl, iss[0], iss[1]};
        e.ie  = vis(m_pipe[0]);
        e.em  = vis(m_pipe[1]);
        e.mw  = vis(m_pipe[2]);
    endtask

    task automatic step(input stim_t s, input logic rst_v);
        exp_t e;
        @(posedge clk);
        if (rst_n) model_advance();
        else model_clear();
        #1;
        rst_n = rst_v;
        cur = s;
        compute(s, e);
        q.push_back(e);
    endtask

    // monitor: the DUT presents a fresh response every cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 4;
            if ({stall, issue0, issue1} !== e.ctl) begin
                errors++;
                $display("FAIL ctl t=%0t stall/iss0/iss1 got %b want %b",
                         $time, {stall, issue0, issue1}, e.ctl);
            end
            if ({ie_rd0, ie_rd1, ie_rw0, ie_rw1, ie_f} !== e.ie) begin
                errors++;
                $display("FAIL id_ex t=%0t got %h want %h", $time,
                         {ie_rd0, ie_rd1, ie_rw0, ie_rw1, ie_f}, e.ie);
            end
            if ({em_rd0, em_rd1, em_rw0, em_rw1, em_f} !== e.em) begin
                errors++;
                $display("FAIL ex_mem t=%0t got %h want %h", $time,
                         {em_rd0, em_rd1, em_rw0, em_rw1, em_f}, e.em);
            end
            if ({mw_rd0, mw_rd1, mw_rw0, mw_rw1, mw_f} !== e.mw) begin
                errors++;
                $display("FAIL mem_wb t=%0t got %h want %h", $time,
                         {mw_rd0, mw_rd1, mw_rw0, mw_rw1, mw_f}, e.mw);
            end
        end
    end

    function automatic stim_t rand_stim();
        stim_t s;
        s.vl0 = $urandom_range(0, 7) != 0;
        s.vl1 = $urandom_range(0, 7) != 0;
        s.rs0 = R'($urandom_range(0, 7));
        s.rt0 = R'($urandom_range(0, 7));
        s.rs1 = R'($urandom_range(0, 7));
        s.rt1 = R'($urandom_range(0, 7));
        s.rd0 = R'($urandom_range(0, 7));
        s.rd1 = R'($urandom_range(0, 7));
        s.wr0 = $urandom_range(0, 3) != 0;
        s.wr1 = $urandom_range(0, 3) != 0;
        s.ld0 = $urandom_range(0, 2) == 0;
        s.ld1 = $urandom_range(0, 2) == 0;
        s.first = 1'($urandom_range(0, 1));
        s.fl  = $urandom_range(0, 15) == 0;
        return s;
    endfunction

    function automatic stim_t bundle(logic v0, logic v1, logic fst,
        logic [R-1:0] rd0, logic w0, logic l0, logic [R-1:0] rs0,
        logic [R-1:0] rt0, logic [R-1:0] rd1, logic w1, logic l1,
        logic [R-1:0] rs1, logic [R-1:0] rt1, logic fl);
        stim_t s;
        s.vl0 = v0;  s.vl1 = v1;  s.first = fst;  s.fl = fl;
        s.rd0 = rd0; s.wr0 = w0;  s.ld0 = l0; s.rs0 = rs0; s.rt0 = rt0;
        s.rd1 = rd1; s.wr1 = w1;  s.ld1 = l1; s.rs1 = rs1; s.rt1 = rt1;
        return s;
    endfunction

    stim_t idle, b;

    initial begin
        idle = '0;
        cur = '0;
        rst_n = 1'b0;
        model_clear();
        step(idle, 1'b0);
        step(idle, 1'b0);
        step(idle, 1'b1);
        // load r5 in slot0, then a reader of r5 stalls one cycle
        step(bundle(1, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        b = bundle(1, 1, 1, 4, 1, 0, 5, 2, 9, 1, 0, 1, 2, 0);
        step(b, 1'b1);
        step(b, 1'b1);
        step(idle, 1'b1);
        // intra-bundle RAW on r3 splits the bundle
        b = bundle(1, 1, 1, 3, 1, 0, 1, 2, 6, 1, 0, 4, 3, 0);
        step(b, 1'b1);
        step(b, 1'b1);
        // older load r7 feeding the younger: split then load-use
        b = bundle(1, 1, 1, 7, 1, 1, 1, 2, 6, 1, 0, 7, 2, 0);
        step(b, 1'b1);
        step(b, 1'b1);
        step(b, 1'b1);
        // flush while split and load-use coincide
        step(b, 1'b1);
        b.fl = 1'b1;
        step(b, 1'b1);
        b.fl = 1'b0;
        step(b, 1'b1);
        step(b, 1'b1);
        step(b, 1'b1);
        // load to r0 never causes a stall; id_first=0 ordering
        step(bundle(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        step(bundle(1, 1, 0, 2, 1, 0, 0, 0, 3, 1, 0, 0, 1, 0), 1'b1);
        step(bundle(1, 1, 0, 2, 1, 0, 4, 5, 3, 1, 0, 3, 1, 0), 1'b1);
        step(idle, 1'b1);
        // async reset while split, then release with the same bundle
        b = bundle(1, 1, 1, 3, 1, 0, 1, 2, 6, 1, 0, 3, 3, 0);
        step(b, 1'b1);
        step(b, 1'b0);
        step(b, 1'b0);
        step(b, 1'b1);
        step(b, 1'b1);
        for (int n = 0; n < 600; n++) begin
            if (m_last_stall && $urandom_range(0, 7) != 0) begin
                b = cur;
                b.fl = $urandom_range(0, 15) == 0;
            end else begin
                b = rand_stim();
            end
            step(b, 1'b1);
        end
        step(idle, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ZERO_REG_WRITES, default 0, meaning 0 suppresses reg_write for any rd==0 entering id_ex, 1 passes it unchanged.
REQ-002 SHALL have clk, input, 1, single clock for all state; every flop samples on the rising edge.
REQ-003 SHALL have rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have id_valid0/id_valid1, input, 1 each, decode slot holds a real instruction.
REQ-005 SHALL have id_rs0/id_rt0/id_rs1/id_rt1/id_rd0/id_rd1, input, `NUM_REGISTERS_LOG2 each, decode slot source and destination registers.
REQ-006 SHALL have id_reg_write0/1 and id_mem_read0/1, input, 1 each, slot writes a register / slot is a load.
REQ-007 SHALL have id_first, input, 1, 1 = slot1 is the younger instruction of the bundle.
REQ-008 SHALL have flush, input, 1, synchronous squash of decode and id_ex.
REQ-009 SHALL have stall, output, 1, hold IF/ID this cycle.
REQ-010 SHALL have issue0/issue1, output, 1 each, slot enters id_ex at the next edge.
REQ-011 SHALL have id_ex_*, ex_mem_*, mem_wb_* {rd0, rd1: `NUM_REGISTERS_LOG2; reg_write0, reg_write1, first: 1}, output, registered stage tags driving the forwarding unit.

Function
REQ-012 SHALL advance tags every cycle with no backend stall: id_ex -> ex_mem -> mem_wb; the mem_wb contents are discarded after one cycle.
REQ-013 SHALL load into id_ex the issued slot's rd, reg_write and id_first.
REQ-014 SHALL clear reg_write in id_ex for any non-issued slot, making it a bubble.
REQ-015 SHALL define load-use as follows: id_ex slot k has mem_read and reg_write, and its rd equals rs or rt of a valid, not-yet-issued decode slot.
REQ-016 SHALL, on load-use, set stall=1, issue0=issue1=0, and leave the state unchanged.
REQ-017 SHALL define an intra-bundle hazard as follows: both slots valid, the older slot has reg_write, and its rd equals the younger slot's rs or rt.
REQ-018 SHALL implement FSM states NORMAL and SPLIT; the reset state is NORMAL.
REQ-019 SHALL, in NORMAL with no load-use and no intra hazard, issue all valid slots with stall=0.
REQ-020 SHALL, in NORMAL on an intra hazard without load-use, issue the older slot only, set stall=1, and go to SPLIT.
REQ-021 SHALL, in SPLIT, consider only the younger slot.
REQ-022 SHALL, in SPLIT with no load-use, issue the younger slot, set stall=0, and go to NORMAL.
REQ-023 SHALL, in SPLIT on load-use, issue nothing, set stall=1, and remain in SPLIT.
REQ-024 SHALL give load-use priority over intra hazard.
REQ-025 SHALL never treat an rd of 0 as a hazard source.
REQ-026 SHALL, on flush, force issue0=issue1=0, stall=0, clear id_ex reg_write/mem_read, and return to NORMAL.
REQ-027 SHALL, on flush, let ex_mem and mem_wb advance normally.
REQ-028 SHALL give flush priority over stall, split and load-use in the same cycle.
REQ-029 SHALL produce stall/issue combinationally in the same cycle from the id inputs, the id_ex tags and the state, with zero-cycle latency.

Reset
REQ-030 SHALL, while rst_n=0, clear all tag flops to 0 (rd, reg_write, mem_read, first), set state=NORMAL, and drive stall=0 and issue0=issue1=0.
REQ-031 SHALL take effect on assertion mid-SPLIT immediately, discarding the pending younger slot.

Structure
REQ-032 SHALL take `NUM_REGISTERS_LOG2 from defines.vh and add FSM state encodings SB_NORMAL/SB_SPLIT there.
REQ-033 SHALL use one sub-module, sb_stage_reg, instantiated three times, holding one stage's tags with async-low reset and a bubble input.

Verification
REQ-034 SHALL verify: id_ex slot0 is a load with rd=5 and reg_write, decode slot0 rs=5 valid -> stall=1, issue=00 for 1 cycle, then issue=11.
REQ-035 SHALL verify: id_first=1, slot0 rd=3 with reg_write, slot1 rt=3 -> cycle N issue0=1, stall=1 (SPLIT); N+1 issue1=1, stall=0 (NORMAL).
REQ-036 SHALL verify: SPLIT where the older slot is a load rd=7 and the younger reads r7 -> N+1 issue=00, stall=1; N+2 issue1=1.
REQ-037 SHALL verify: flush asserted in SPLIT together with load-use -> stall=0, issue=00, next state NORMAL, id_ex reg_write cleared, ex_mem gets the previous id_ex.
REQ-038 SHALL verify: a load with rd=0 followed by a reader of r0 -> no stall; with ZERO_REG_WRITES=0, id_ex_reg_write=0.
REQ-039 SHALL verify: rst_n pulsed low asynchronously mid-SPLIT between edges -> all tags 0, stall=0, state NORMAL before the next edge.
